// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA source scheduler:
//   - FSM state encoding (SHOW / PEND / BLANK)
//   - active-area geometry (H_VALID x V_VALID)
//   - PIX_INVALID marker used by the timing controller outside the active area
//   - RGB565 BLACK
//   - small pixel-coordinate helper functions
// -----------------------------------------------------------------------------
package vga_pkg;

    // Scheduler states
    localparam logic [1:0] ST_SHOW  = 2'd0;   // source displayed, dwell counting
    localparam logic [1:0] ST_PEND  = 2'd1;   // advance requested, waiting for frame start
    localparam logic [1:0] ST_BLANK = 2'd2;   // black frames after a source change

    // Active area geometry
    localparam int H_VALID = 640;
    localparam int V_VALID = 480;

    // Coordinate value reported outside the active area
    localparam logic [9:0] PIX_INVALID = 10'h3FF;

    // RGB565 black
    localparam logic [15:0] BLACK = 16'h0000;

    // True when both coordinates lie inside the active area
    function automatic logic pix_valid(input logic [9:0] x, input logic [9:0] y);
        return (x != PIX_INVALID) && (y != PIX_INVALID);
    endfunction

    // True on the top-left pixel of the frame
    function automatic logic pix_origin(input logic [9:0] x, input logic [9:0] y);
        return (x == 10'd0) && (y == 10'd0);
    endfunction

endpackage

// File: rtl/vga_rr_pick.sv
// -----------------------------------------------------------------------------
// vga_rr_pick
// Round-robin picker: starting just above cur_idx and wrapping at NUM_SRC-1,
// returns the first index whose enable bit is set. The current index itself is
// never returned as a "found" result.
// Ports:
//   cur_idx  in  2        index of the source currently shown
//   en_mask  in  NUM_SRC  per-source enable mask
//   nxt_idx  out 2        next enabled index (cur_idx when none found)
//   found    out 1        an enabled index other than cur_idx exists
// Purely combinational.
// -----------------------------------------------------------------------------
module vga_rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [1:0]         cur_idx,
    input  logic [NUM_SRC-1:0] en_mask,
    output logic [1:0]         nxt_idx,
    output logic               found
);

    logic [3:0] mask4_s;

    assign mask4_s = 4'(en_mask);

    // (cur + off) modulo NUM_SRC, off in 1..NUM_SRC-1
    function automatic logic [1:0] wrap_add(input logic [1:0] cur, input int off);
        int sum;
        sum = int'(cur) + off;
        sum = (sum >= NUM_SRC) ? (sum - NUM_SRC) : sum;
        return 2'(sum);
    endfunction

    // Scan offsets from farthest to nearest so the nearest hit is written last
    always_comb begin
        logic [1:0] cand;
        logic       hit;
        nxt_idx = cur_idx;
        found   = 1'b0;
        cand    = 2'd0;
        hit     = 1'b0;
        for (int off = NUM_SRC - 1; off >= 1; off--) begin
            cand    = wrap_add(cur_idx, off);
            hit     = mask4_s[cand];
            nxt_idx = hit ? cand : nxt_idx;
            found   = found | hit;
        end
    end

endmodule

// File: rtl/vga_src_sched.sv
// -----------------------------------------------------------------------------
// vga_src_sched
// Picture source scheduler for a VGA pipeline. Shows one of NUM_SRC RGB565
// sources, advances to the next enabled source on a key press, on dwell expiry
// (auto_en) or when the shown source gets disabled, and inserts BLANK_FRAMES
// black frames on every change. Source changes happen only at frame start.
// Ports:
//   vga_clk    in  1           pixel clock (single domain)
//   sys_rst_n  in  1           asynchronous active-low reset
//   pix_x      in  10          pixel x, 0x3FF outside active area
//   pix_y      in  10          pixel y, 0x3FF outside active area
//   src_data   in  16*NUM_SRC  RGB565 per source, source k at [16k+15:16k]
//   src_en     in  NUM_SRC     per-source enable mask
//   key_next   in  1           one-cycle manual advance request
//   auto_en    in  1           enable dwell-based auto advance
//   pix_data   out 16          registered RGB565 output (1-cycle latency)
//   src_sel    out 2           index of the source shown
//   blanking   out 1           high while black frames are inserted
// -----------------------------------------------------------------------------
module vga_src_sched
    import vga_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_FRAMES = 60,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                   vga_clk,
    input  logic                   sys_rst_n,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic [16*NUM_SRC-1:0]  src_data,
    input  logic [NUM_SRC-1:0]     src_en,
    input  logic                   key_next,
    input  logic                   auto_en,
    output logic [15:0]            pix_data,
    output logic [1:0]             src_sel,
    output logic                   blanking
);

    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [BW-1:0] BLANK_LAST = (BLANK_FRAMES > 0) ? BW'(BLANK_FRAMES - 1) : '0;
    localparam bit            HAS_BLANK  = (BLANK_FRAMES > 0);

    // Registered state
    logic          origin_q;
    logic [1:0]    state_q,    state_d;
    logic [1:0]    src_sel_q,  src_sel_d;
    logic [DW-1:0] dwell_q,    dwell_d;
    logic [BW-1:0] blank_q,    blank_d;
    logic [15:0]   pix_data_q, pix_data_d;
    logic          blanking_q, blanking_d;

    // Combinational helpers
    logic          origin_s;
    logic          frame_start_s;
    logic [3:0]    en4_s;
    logic          cur_en_s;
    logic          dwell_hit_s;
    logic          adv_req_s;
    logic [1:0]    pick_idx_s;
    logic          pick_found_s;
    logic [63:0]   data64_s;
    logic [15:0]   show_pix_s;

    // Frame start: rising edge of "at origin", so a held origin pulses once
    assign origin_s      = pix_origin(pix_x, pix_y);
    assign frame_start_s = origin_s & ~origin_q;

    assign en4_s       = 4'(src_en);
    assign cur_en_s    = en4_s[src_sel_q];
    assign dwell_hit_s = (dwell_q == DWELL_LAST);

    // Any advance source collapses into one request; a disabled current source
    // behaves exactly like a key press
    assign adv_req_s = key_next | ~cur_en_s | (auto_en & frame_start_s & dwell_hit_s);

    vga_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .cur_idx (src_sel_q),
        .en_mask (src_en),
        .nxt_idx (pick_idx_s),
        .found   (pick_found_s)
    );

    // Scheduler FSM with dwell and blank frame counters
    always_comb begin
        state_d   = state_q;
        src_sel_d = src_sel_q;
        dwell_d   = dwell_q;
        blank_d   = blank_q;
        case (state_q)
            ST_SHOW: begin
                // Saturating dwell count of frame starts seen while showing
                if (frame_start_s && !dwell_hit_s) begin
                    dwell_d = dwell_q + DW'(1);
                end else begin
                    dwell_d = dwell_q;
                end
                if (adv_req_s) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_SHOW;
                end
            end
            ST_PEND: begin
                // Held at zero so SHOW always starts a fresh dwell
                dwell_d = '0;
                if (frame_start_s) begin
                    if (pick_found_s) begin
                        src_sel_d = pick_idx_s;
                        blank_d   = '0;
                        if (HAS_BLANK) begin
                            state_d = ST_BLANK;
                        end else begin
                            state_d = ST_SHOW;
                        end
                    end else begin
                        // Nothing else to show: drop the request, keep source
                        state_d = ST_SHOW;
                    end
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_BLANK: begin
                dwell_d = '0;
                if (frame_start_s) begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        blank_d = '0;
                    end else begin
                        state_d = ST_BLANK;
                        blank_d = blank_q + BW'(1);
                    end
                end else begin
                    state_d = ST_BLANK;
                end
            end
            default: begin
                state_d   = ST_SHOW;
                src_sel_d = 2'd0;
                dwell_d   = '0;
                blank_d   = '0;
            end
        endcase
    end

    // Output pixel selection; uses next-state values so the first pixel of a
    // frame already reflects the source/blanking decided at that frame start
    assign data64_s   = 64'(src_data);
    assign show_pix_s = data64_s[{src_sel_d, 4'b0000} +: 16];

    // Output pixel and blanking flag, registered below
    always_comb begin
        blanking_d = (state_d == ST_BLANK);
        if (blanking_d || !pix_valid(pix_x, pix_y)) begin
            pix_data_d = BLACK;
        end else begin
            pix_data_d = show_pix_s;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            origin_q   <= 1'b0;
            state_q    <= ST_SHOW;
            src_sel_q  <= 2'd0;
            dwell_q    <= '0;
            blank_q    <= '0;
            pix_data_q <= BLACK;
            blanking_q <= 1'b0;
        end else begin
            origin_q   <= origin_s;
            state_q    <= state_d;
            src_sel_q  <= src_sel_d;
            dwell_q    <= dwell_d;
            blank_q    <= blank_d;
            pix_data_q <= pix_data_d;
            blanking_q <= blanking_d;
        end
    end

    assign pix_data = pix_data_q;
    assign src_sel  = src_sel_q;
    assign blanking = blanking_q;

endmodule

// File: tb/tb_vga_src_sched.sv
// -----------------------------------------------------------------------------
// tb_vga_src_sched
// Drives small synthetic frames (8x4 active pixels plus invalid-coordinate
// cycles) into vga_src_sched with NUM_SRC=4, DWELL_FRAMES=3, BLANK_FRAMES=2.
// Part 1: frame-level table of {inputs, expected source/blanking}.
// Part 2: reset asserted while blanking.
// Part 3: random stimulus compared each cycle against a frame-level model.
// -----------------------------------------------------------------------------
module tb_vga_src_sched;

    localparam int N  = 4;
    localparam int DF = 3;
    localparam int BF = 2;

    logic          vga_clk;
    logic          sys_rst_n;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic [63:0]   src_data;
    logic [3:0]    src_en;
    logic          key_next;
    logic          auto_en;
    logic [15:0]   pix_data;
    logic [1:0]    src_sel;
    logic          blanking;

    vga_src_sched #(
        .NUM_SRC      (N),
        .DWELL_FRAMES (DF),
        .BLANK_FRAMES (BF)
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .src_data  (src_data),
        .src_en    (src_en),
        .key_next  (key_next),
        .auto_en   (auto_en),
        .pix_data  (pix_data),
        .src_sel   (src_sel),
        .blanking  (blanking)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int checks   = 0;
    int failures = 0;
    bit rand_mode = 1'b0;

    logic [15:0] fdata [4] = '{16'h001F, 16'hF800, 16'h07E0, 16'hA5A5};

    // captured mid-frame samples
    logic [1:0]  cap_sel;
    logic        cap_blk;
    logic [15:0] cap_pix;
    logic [15:0] cap_inv;

    // Frame-level reference model: which source is shown, whether an advance
    // is waiting, how many black frames remain, frame starts seen while showing
    int          m_sel;
    bit          m_pend;
    int          m_blank_left;
    int          m_shown;
    bit          m_prev_origin;
    logic [15:0] m_pix;

    typedef struct {
        bit         rst;
        bit         auto_e;
        logic [3:0] en;
        int         keypos;
        logic [1:0] exp_sel;
        bit         exp_blk;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit origin, fs, req, found;
        int nxt;
        origin = (pix_x == 10'd0) && (pix_y == 10'd0);
        fs = origin && !m_prev_origin;
        m_prev_origin = origin;
        if (!m_pend && m_blank_left == 0) begin
            req = key_next || !src_en[m_sel] || (auto_en && fs && m_shown >= DF - 1);
            if (fs) m_shown++;
            if (req) m_pend = 1'b1;
        end else if (m_pend) begin
            if (fs) begin
                found = 1'b0;
                nxt = m_sel;
                for (int i = 1; i < N; i++) begin
                    if (!found && src_en[(m_sel + i) % N]) begin
                        found = 1'b1;
                        nxt = (m_sel + i) % N;
                    end
                end
                m_pend = 1'b0;
                m_shown = 0;
                if (found) begin
                    m_sel = nxt;
                    m_blank_left = BF;
                end
            end
        end else begin
            if (fs) begin
                m_blank_left--;
                if (m_blank_left == 0) m_shown = 0;
            end
        end
        m_pix = (m_blank_left > 0 || pix_x == 10'h3FF || pix_y == 10'h3FF)
                ? 16'h0000 : src_data[16*m_sel +: 16];
    endtask

    task automatic cycle(input logic [9:0] x, input logic [9:0] y, input bit k);
        pix_x = x;
        pix_y = y;
        key_next = k;
        if (rand_mode) begin
            src_data = {$urandom, $urandom};
            if ($urandom_range(0, 79) == 0) src_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) key_next = 1'b1;
            model_step();
        end
        @(posedge vga_clk);
        #1;
        key_next = 1'b0;
        if (rand_mode) begin
            check("rnd_sel", 16'(src_sel), 16'(m_sel));
            check("rnd_blank", 16'(blanking), 16'(m_blank_left > 0));
            check("rnd_pix", pix_data, m_pix);
        end
    endtask

    task automatic run_frame(input int hold, input int keypos);
        int idx;
        idx = 0;
        for (int h = 0; h < hold; h++) begin
            cycle(10'd0, 10'd0, idx == keypos);
            idx++;
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (!(x == 0 && y == 0)) begin
                    cycle(10'(x), 10'(y), idx == keypos);
                    idx++;
                    if (x == 2 && y == 2) begin
                        cap_sel = src_sel;
                        cap_blk = blanking;
                        cap_pix = pix_data;
                    end
                end
            end
            cycle(10'h3FF, 10'(y), idx == keypos);
            idx++;
        end
        for (int t = 0; t < 4; t++) begin
            cycle(10'h3FF, 10'h3FF, idx == keypos);
            idx++;
        end
        cap_inv = pix_data;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        pix_x = 10'h3FF;
        pix_y = 10'h3FF;
        key_next = 1'b0;
        #13;
        check("rst_pix", pix_data, 16'h0000);
        check("rst_sel", 16'(src_sel), 16'h0000);
        check("rst_blank", 16'(blanking), 16'h0000);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        m_sel = 0;
        m_pend = 1'b0;
        m_blank_left = 0;
        m_shown = 0;
        m_prev_origin = 1'b0;
    endtask

    function automatic void add(bit r, bit a, logic [3:0] e, int kp, logic [1:0] s, bit b);
        vec_t v;
        v.rst = r; v.auto_e = a; v.en = e; v.keypos = kp; v.exp_sel = s; v.exp_blk = b;
        tbl.push_back(v);
    endfunction

    function automatic void add_n(int n, bit a, logic [3:0] e, logic [1:0] s, bit b);
        for (int i = 0; i < n; i++) add(1'b0, a, e, -1, s, b);
    endfunction

    initial begin
        sys_rst_n = 1'b0;
        pix_x = 10'h3FF;
        pix_y = 10'h3FF;
        key_next = 1'b0;
        auto_en = 1'b0;
        src_en = 4'hF;
        src_data = {fdata[3], fdata[2], fdata[1], fdata[0]};

        // Auto advance: 0,1,2,3,0 with two black frames per change
        add(1'b1, 1'b1, 4'hF, -1, 2'd0, 1'b0);
        add_n(2, 1'b1, 4'hF, 2'd0, 1'b0);
        add_n(2, 1'b1, 4'hF, 2'd1, 1'b1);
        add_n(4, 1'b1, 4'hF, 2'd1, 1'b0);
        add_n(2, 1'b1, 4'hF, 2'd2, 1'b1);
        add_n(4, 1'b1, 4'hF, 2'd2, 1'b0);
        add_n(2, 1'b1, 4'hF, 2'd3, 1'b1);
        add_n(4, 1'b1, 4'hF, 2'd3, 1'b0);
        add_n(2, 1'b1, 4'hF, 2'd0, 1'b1);
        add_n(1, 1'b1, 4'hF, 2'd0, 1'b0);
        // Manual key in frame 10
        add(1'b1, 1'b0, 4'hF, -1, 2'd0, 1'b0);
        add_n(9, 1'b0, 4'hF, 2'd0, 1'b0);
        add(1'b0, 1'b0, 4'hF, 12, 2'd0, 1'b0);
        add_n(2, 1'b0, 4'hF, 2'd1, 1'b1);
        add_n(2, 1'b0, 4'hF, 2'd1, 1'b0);
        // Sparse mask 1001: 0 -> 3 -> wraps to 0
        add(1'b1, 1'b0, 4'h9, 12, 2'd0, 1'b0);
        add_n(2, 1'b0, 4'h9, 2'd3, 1'b1);
        add(1'b0, 1'b0, 4'h9, 12, 2'd3, 1'b0);
        add_n(2, 1'b0, 4'h9, 2'd0, 1'b1);
        add_n(1, 1'b0, 4'h9, 2'd0, 1'b0);
        // Single enabled source: no blanking, back to SHOW next frame
        add(1'b1, 1'b0, 4'h1, 12, 2'd0, 1'b0);
        add_n(1, 1'b0, 4'h1, 2'd0, 1'b0);
        add(1'b0, 1'b0, 4'h3, 12, 2'd0, 1'b0);
        add_n(1, 1'b0, 4'h3, 2'd1, 1'b1);
        // Key coincident with dwell expiry, extra key while blanking
        add(1'b1, 1'b1, 4'hF, -1, 2'd0, 1'b0);
        add_n(1, 1'b1, 4'hF, 2'd0, 1'b0);
        add(1'b0, 1'b1, 4'hF, 0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 4'hF, 12, 2'd1, 1'b1);
        add_n(1, 1'b1, 4'hF, 2'd1, 1'b1);
        add_n(3, 1'b1, 4'hF, 2'd1, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            auto_en = tbl[i].auto_e;
            src_en = tbl[i].en;
            run_frame(1, tbl[i].keypos);
            check($sformatf("tbl%0d_sel", i), 16'(cap_sel), 16'(tbl[i].exp_sel));
            check($sformatf("tbl%0d_blank", i), 16'(cap_blk), 16'(tbl[i].exp_blk));
            check($sformatf("tbl%0d_pix", i), cap_pix,
                  tbl[i].exp_blk ? 16'h0000 : fdata[tbl[i].exp_sel]);
            check($sformatf("tbl%0d_inv", i), cap_inv, 16'h0000);
        end

        // Reset pulsed in the middle of a blanking frame
        do_reset();
        auto_en = 1'b0;
        src_en = 4'hF;
        run_frame(1, 12);
        run_frame(1, -1);
        check("r_pre_blank", 16'(blanking), 16'h0001);
        check("r_pre_sel", 16'(src_sel), 16'h0001);
        cycle(10'd0, 10'd0, 1'b0);
        cycle(10'd1, 10'd0, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("r_async_sel", 16'(src_sel), 16'h0000);
        check("r_async_blank", 16'(blanking), 16'h0000);
        check("r_async_pix", pix_data, 16'h0000);
        @(posedge vga_clk);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            run_frame(1, -1);
            check("r_after_sel", 16'(cap_sel), 16'h0000);
            check("r_after_blank", 16'(cap_blk), 16'h0000);
            check("r_after_pix", cap_pix, fdata[0]);
        end

        // Random stimulus against the frame-level model
        do_reset();
        rand_mode = 1'b1;
        for (int f = 0; f < 80; f++) begin
            auto_en = ($urandom_range(0, 3) != 0);
            run_frame($urandom_range(1, 3),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1);
        end
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_src_sched.md
VGA_SRC_SCHED -- requirements
Module: vga_src_sched

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of picture sources (2..4).
REQ-002 SHALL have parameter DWELL_FRAMES, default 60: frames a source is shown before auto-advance.
REQ-003 SHALL have parameter BLANK_FRAMES, default 2: black frames inserted on every source change.
REQ-004 SHALL have port vga_clk  in  1: VGA working clock, 25 MHz; single clock domain.
REQ-005 SHALL have port sys_rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port pix_x  in  10: current pixel x from the timing controller; 0x3FF outside the active area.
REQ-007 SHALL have port pix_y  in  10: current pixel y; 0x3FF outside the active area.
REQ-008 SHALL have port src_data  in  16*NUM_SRC: RGB565 from each source, source k at bits [16k+15:16k].
REQ-009 SHALL have port src_en  in  NUM_SRC: per-source enable mask, sampled at each advance decision.
REQ-010 SHALL have port key_next  in  1: one-cycle request pulse for a manual advance, already debounced.
REQ-011 SHALL have port auto_en  in  1: enables dwell-based auto-advance.
REQ-012 SHALL have port pix_data  out  16: RGB565 to the timing controller.
REQ-013 SHALL have port src_sel  out  2: index of the source currently shown.
REQ-014 SHALL have port blanking  out  1: high while in BLANK.

Function
REQ-015 SHALL generate frame_start as a one-cycle pulse on the first cycle where pix_x==0 and pix_y==0, at most one pulse per frame.
REQ-016 SHALL implement the FSM states SHOW, PEND and BLANK.
REQ-017 SHOW->PEND SHALL occur on key_next, or when auto_en is set and dwell_cnt==DWELL_FRAMES-1 at frame_start; if both happen in the same cycle, exactly one advance SHALL result.
REQ-018 In PEND and BLANK, further key_next pulses and dwell expiries SHALL be ignored, with no queueing.
REQ-019 PEND->BLANK SHALL occur on frame_start; on that same edge src_sel SHALL update to the next enabled index above the current one, wrapping from NUM_SRC-1 to 0.
REQ-020 If no other source is enabled at the PEND decision, src_sel SHALL be unchanged and the FSM SHALL return to SHOW without blanking.
REQ-021 BLANK SHALL count frame_start pulses in blank_cnt; at blank_cnt==BLANK_FRAMES-1 and frame_start the FSM SHALL go to SHOW.
REQ-022 With BLANK_FRAMES==0, PEND SHALL go directly to SHOW.
REQ-023 dwell_cnt SHALL clear on entry to SHOW, increment on each frame_start while in SHOW, and saturate at DWELL_FRAMES-1.
REQ-024 pix_data SHALL be registered with 1-cycle latency: 0x0000 when in BLANK or when pix_x/pix_y equals 0x3FF, otherwise src_data[src_sel].
REQ-025 If the currently shown source is disabled mid-SHOW, an implicit advance request SHALL be raised, processed as key_next.
REQ-026 src_sel SHALL change only at a frame_start edge, so there is no mid-frame source tear.

Reset
REQ-027 On sys_rst_n low, asynchronously: state=SHOW, src_sel=0, dwell_cnt=0, blank_cnt=0, pix_data=0x0000, blanking=0, frame_start detector cleared.
REQ-028 Reset asserted mid-PEND or mid-BLANK SHALL abandon the switch; after release the block shows source 0 from the next frame.
REQ-029 No output SHALL depend on vga_clk running while reset is asserted.

Structure
REQ-030 A shared package vga_pkg SHALL hold the FSM state encoding, H_VALID=640, V_VALID=480, PIX_INVALID=10'h3FF and the RGB565 BLACK constant.
REQ-031 The next-enabled-index search SHALL be a sub-module vga_rr_pick (round-robin picker: current index + mask -> next index + found flag).
REQ-032 The source mux and output register SHALL stay in vga_src_sched.

Verification
REQ-033 Reset, auto_en=1, DWELL_FRAMES=3, BLANK_FRAMES=2, src_en=4'b1111 -> src_sel runs 0,1,2,3,0 and each change is followed by exactly 2 frames of pix_data=0x0000.
REQ-034 key_next at mid-frame of frame 10, src_data1=16'hF800 -> src_sel=1 from frame 11, blanking frames 11-12, pix_data=16'hF800 from frame 13.
REQ-035 src_en=4'b1001 with src_sel=0, advance -> src_sel=3, then the next advance wraps to 0.
REQ-036 src_en=4'b0001, key_next -> no blanking, src_sel stays 0, FSM back in SHOW within 1 frame.
REQ-037 key_next and dwell expiry in the same cycle, plus a second key_next during BLANK -> exactly one increment of src_sel.
REQ-038 sys_rst_n pulsed low during BLANK -> outputs 0 immediately, src_sel=0, normal display of source 0 after release.
